// File: rtl/l2_domain_reset_sequencer_if.sv
// Request, drain and clock/reset control bundle of the L2 domain reset sequencer.
// master drives request and drain_ack; slave is the sequencer.
interface l2_domain_reset_sequencer_if;
   logic req_valid;
   logic req_ready;
   logic drain_req;
   logic drain_ack;
   logic clock_en;
   logic domain_reset;
   logic busy;
   logic done;
   logic timeout_flag;

   modport master (
      output req_valid,
      output drain_ack,
      input  req_ready,
      input  drain_req,
      input  clock_en,
      input  domain_reset,
      input  busy,
      input  done,
      input  timeout_flag
   );

   modport slave (
      input  req_valid,
      input  drain_ack,
      output req_ready,
      output drain_req,
      output clock_en,
      output domain_reset,
      output busy,
      output done,
      output timeout_flag
   );
endinterface

// File: rtl/l2_domain_reset_sequencer.sv
// L2 domain reset sequencer: drain, gate, hold reset, gate, run.
// Optional drain-ack timeout enabled by defining L2_RST_SEQ_TIMEOUT_EN.
module l2_domain_reset_sequencer #(
   parameter int HOLD_CYCLES    = 16,
   parameter int SETTLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 9
) (
   input logic clock,
   input logic reset,
   l2_domain_reset_sequencer_if.slave ctl
);

   typedef enum logic [2:0] {
      RUN,
      DRAIN,
      GATE_A,
      HOLD,
      GATE_B
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LD  = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef L2_RST_SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic             cnt_zero;
   logic             accept;
   logic             drain_to;

   logic             drain_req_q;
   logic             clock_en_q;
   logic             domain_reset_q;
   logic             req_ready_q;
   logic             busy_q;
   logic             done_q;

   assign cnt_zero = (cnt == '0);
   assign accept   = (state == RUN) && ctl.req_valid;
   // ack wins over an expiring count on the same cycle
   assign drain_to = TO_EN && (state == DRAIN)
                     && !ctl.drain_ack && cnt_zero;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         RUN: begin
            if (accept) begin
               state_nx = DRAIN;
               cnt_nx   = DRAIN_LD;
            end
         end
         DRAIN: begin
            if (ctl.drain_ack || drain_to) begin
               state_nx = GATE_A;
               cnt_nx   = SETTLE_LD;
            end else if (TO_EN) begin
               cnt_nx = cnt - 1'b1;
            end
         end
         GATE_A: begin
            if (cnt_zero) begin
               state_nx = HOLD;
               cnt_nx   = HOLD_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_zero) begin
               state_nx = GATE_B;
               cnt_nx   = SETTLE_LD;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         GATE_B: begin
            if (cnt_zero) begin
               state_nx = RUN;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - 1'b1;
            end
         end
         default: begin
            state_nx = HOLD;
            cnt_nx   = HOLD_LD;
         end
      endcase
   end

   // outputs are registered from the next state so they track the state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= HOLD;
         cnt            <= HOLD_LD;
         done_q         <= 1'b0;
         drain_req_q    <= 1'b0;
         clock_en_q     <= 1'b1;
         domain_reset_q <= 1'b1;
         req_ready_q    <= 1'b0;
         busy_q         <= 1'b1;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         done_q         <= (state == GATE_B) && (state_nx == RUN);
         drain_req_q    <= (state_nx == DRAIN);
         clock_en_q     <= !((state_nx == GATE_A) || (state_nx == GATE_B));
         domain_reset_q <= (state_nx == HOLD);
         req_ready_q    <= (state_nx == RUN);
         busy_q         <= (state_nx != RUN);
      end
   end

`ifdef L2_RST_SEQ_TIMEOUT_EN
   logic tflag;

   always_ff @(posedge clock) begin
      if (reset) begin
         tflag <= 1'b0;
      end else if (drain_to) begin
         tflag <= 1'b1;
      end else if (accept) begin
         tflag <= 1'b0;
      end
   end

   assign ctl.timeout_flag = tflag;
`else
   assign ctl.timeout_flag = 1'b0;
`endif

   assign ctl.drain_req    = drain_req_q;
   assign ctl.clock_en     = clock_en_q;
   assign ctl.domain_reset = domain_reset_q;
   assign ctl.req_ready    = req_ready_q;
   assign ctl.busy         = busy_q;
   assign ctl.done         = done_q;

endmodule

// File: tb/tb_l2_domain_reset_sequencer.sv
// Directed bench for l2_domain_reset_sequencer.
// Covers L2_RST_SEQ_TIMEOUT_EN defined or undefined.
module tb_l2_domain_reset_sequencer;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   l2_domain_reset_sequencer_if ctl ();

   l2_domain_reset_sequencer dut (
      .clock (clock),
      .reset (reset),
      .ctl   (ctl)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // walk a sequence until busy drops, tallying cycles per output pattern
   task automatic measure(input int ack_at, input int budget,
                          output int nb, output int nd, output int ng,
                          output int nh, output logic tf_gate,
                          output logic expired);
      nb = 0; nd = 0; ng = 0; nh = 0;
      tf_gate = 1'b0;
      expired = 1'b0;
      while (ctl.busy === 1'b1) begin
         if (nb >= budget) begin
            expired = 1'b1;
            break;
         end
         nb++;
         if (ctl.drain_req === 1'b1) begin
            nd++;
            if (nd == ack_at) ctl.drain_ack = 1'b1;
         end
         if (ctl.clock_en === 1'b0) begin
            if (ng == 0) tf_gate = ctl.timeout_flag;
            ng++;
         end
         if (ctl.domain_reset === 1'b1) nh++;
         step();
      end
   endtask

   task automatic request();
      ctl.req_valid = 1'b1;
      step();
      ctl.req_valid = 1'b0;
   endtask

   task automatic test_reset();
      int nb, nd, ng, nh;
      logic tf, ex;
      reset = 1'b1;
      repeat (3) step();
      n_checks++; if (ctl.domain_reset !== 1'b1) begin n_fail++; $display("FAIL rst_domain_reset: got %b want 1", ctl.domain_reset); end
      n_checks++; if (ctl.clock_en !== 1'b1) begin n_fail++; $display("FAIL rst_clock_en: got %b want 1", ctl.clock_en); end
      n_checks++; if ({ctl.drain_req, ctl.req_ready, ctl.busy, ctl.done, ctl.timeout_flag} !== 5'b00100) begin n_fail++; $display("FAIL rst_misc: got %b want 00100", {ctl.drain_req, ctl.req_ready, ctl.busy, ctl.done, ctl.timeout_flag}); end
      reset = 1'b0;
      measure(0, 100, nb, nd, ng, nh, tf, ex);
      n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL por_expired: got %b want 0", ex); end
      n_checks++; if (nb != 20) begin n_fail++; $display("FAIL por_busy: got %0d want 20", nb); end
      n_checks++; if (nh != 16) begin n_fail++; $display("FAIL por_hold: got %0d want 16", nh); end
      n_checks++; if (ng != 4) begin n_fail++; $display("FAIL por_gate: got %0d want 4", ng); end
      n_checks++; if (nd != 0) begin n_fail++; $display("FAIL por_drain: got %0d want 0", nd); end
      n_checks++; if ({ctl.done, ctl.req_ready} !== 2'b11) begin n_fail++; $display("FAIL por_done: got %b want 11", {ctl.done, ctl.req_ready}); end
      step();
      n_checks++; if ({ctl.done, ctl.busy} !== 2'b00) begin n_fail++; $display("FAIL por_idle: got %b want 00", {ctl.done, ctl.busy}); end
   endtask

   task automatic test_late_ack();
      int nb, nd, ng, nh;
      logic tf, ex;
      request();
      measure(5, 200, nb, nd, ng, nh, tf, ex);
      ctl.drain_ack = 1'b0;
      n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL late_expired: got %b want 0", ex); end
      n_checks++; if (nb != 29) begin n_fail++; $display("FAIL late_busy: got %0d want 29", nb); end
      n_checks++; if (nd != 5) begin n_fail++; $display("FAIL late_drain: got %0d want 5", nd); end
      n_checks++; if (ng != 8) begin n_fail++; $display("FAIL late_gate: got %0d want 8", ng); end
      n_checks++; if (nh != 16) begin n_fail++; $display("FAIL late_hold: got %0d want 16", nh); end
      n_checks++; if (ctl.done !== 1'b1) begin n_fail++; $display("FAIL late_done: got %b want 1", ctl.done); end
      step();
   endtask

   task automatic test_early_ack();
      int nb, nd, ng, nh;
      logic tf, ex;
      ctl.drain_ack = 1'b1;
      step();
      n_checks++; if (ctl.busy !== 1'b0) begin n_fail++; $display("FAIL ack_in_run: busy got %b want 0", ctl.busy); end
      request();
      measure(0, 200, nb, nd, ng, nh, tf, ex);
      ctl.drain_ack = 1'b0;
      n_checks++; if (nb != 25) begin n_fail++; $display("FAIL early_busy: got %0d want 25", nb); end
      n_checks++; if (nd != 1) begin n_fail++; $display("FAIL early_drain: got %0d want 1", nd); end
      n_checks++; if (ctl.done !== 1'b1) begin n_fail++; $display("FAIL early_done: got %b want 1", ctl.done); end
      step();
   endtask

   task automatic test_back_to_back();
      int nb, nd, ng, nh;
      logic tf, ex;
      ctl.drain_ack = 1'b1;
      ctl.req_valid = 1'b1;
      step();
      measure(0, 200, nb, nd, ng, nh, tf, ex);
      n_checks++; if (nb != 25) begin n_fail++; $display("FAIL b2b_busy: got %0d want 25", nb); end
      n_checks++; if ({ctl.done, ctl.req_ready} !== 2'b11) begin n_fail++; $display("FAIL b2b_done: got %b want 11", {ctl.done, ctl.req_ready}); end
      step();
      ctl.req_valid = 1'b0;
      n_checks++; if ({ctl.drain_req, ctl.busy, ctl.done} !== 3'b110) begin n_fail++; $display("FAIL b2b_redrain: got %b want 110", {ctl.drain_req, ctl.busy, ctl.done}); end
      measure(0, 200, nb, nd, ng, nh, tf, ex);
      ctl.drain_ack = 1'b0;
      n_checks++; if (nb != 25) begin n_fail++; $display("FAIL b2b_busy2: got %0d want 25", nb); end
      step();
   endtask

   task automatic test_reset_in_hold();
      int nb, nd, ng, nh;
      logic tf, ex;
      ctl.drain_ack = 1'b1;
      request();
      step();
      ctl.drain_ack = 1'b0;
      repeat (4) step();
      repeat (6) step();
      n_checks++; if ({ctl.domain_reset, ctl.clock_en} !== 2'b11) begin n_fail++; $display("FAIL hold7_state: got %b want 11", {ctl.domain_reset, ctl.clock_en}); end
      reset = 1'b1;
      step();
      n_checks++; if ({ctl.domain_reset, ctl.drain_req, ctl.busy} !== 3'b101) begin n_fail++; $display("FAIL hold_abort: got %b want 101", {ctl.domain_reset, ctl.drain_req, ctl.busy}); end
      reset = 1'b0;
      measure(0, 100, nb, nd, ng, nh, tf, ex);
      n_checks++; if (nb != 20) begin n_fail++; $display("FAIL rehold_busy: got %0d want 20", nb); end
      n_checks++; if (nh != 16) begin n_fail++; $display("FAIL rehold_hold: got %0d want 16", nh); end
      n_checks++; if (nd != 0) begin n_fail++; $display("FAIL rehold_drain: got %0d want 0", nd); end
      n_checks++; if (ctl.done !== 1'b1) begin n_fail++; $display("FAIL rehold_done: got %b want 1", ctl.done); end
      step();
   endtask

`ifdef L2_RST_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int nb, nd, ng, nh;
      logic tf, ex;
      request();
      measure(0, 2000, nb, nd, ng, nh, tf, ex);
      n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL to_expired: got %b want 0", ex); end
      n_checks++; if (nd != 256) begin n_fail++; $display("FAIL to_drain: got %0d want 256", nd); end
      n_checks++; if (nb != 280) begin n_fail++; $display("FAIL to_busy: got %0d want 280", nb); end
      n_checks++; if (tf !== 1'b1) begin n_fail++; $display("FAIL to_flag_gate: got %b want 1", tf); end
      n_checks++; if ({ctl.done, ctl.timeout_flag} !== 2'b11) begin n_fail++; $display("FAIL to_flag_done: got %b want 11", {ctl.done, ctl.timeout_flag}); end
      step();
      ctl.drain_ack = 1'b1;
      request();
      n_checks++; if ({ctl.drain_req, ctl.timeout_flag} !== 2'b10) begin n_fail++; $display("FAIL to_clear: got %b want 10", {ctl.drain_req, ctl.timeout_flag}); end
      measure(0, 200, nb, nd, ng, nh, tf, ex);
      ctl.drain_ack = 1'b0;
      n_checks++; if (nb != 25) begin n_fail++; $display("FAIL to_next_busy: got %0d want 25", nb); end
      step();
      request();
      measure(256, 2000, nb, nd, ng, nh, tf, ex);
      ctl.drain_ack = 1'b0;
      n_checks++; if (nd != 256) begin n_fail++; $display("FAIL to_last_drain: got %0d want 256", nd); end
      n_checks++; if ({tf, ctl.timeout_flag} !== 2'b00) begin n_fail++; $display("FAIL to_last_flag: got %b want 00", {tf, ctl.timeout_flag}); end
      step();
   endtask
`else
   task automatic test_no_timeout();
      int nb, nd, ng, nh;
      logic tf, ex;
      request();
      repeat (1000) step();
      n_checks++; if ({ctl.drain_req, ctl.busy, ctl.timeout_flag} !== 3'b110) begin n_fail++; $display("FAIL nto_wait: got %b want 110", {ctl.drain_req, ctl.busy, ctl.timeout_flag}); end
      ctl.drain_ack = 1'b1;
      measure(0, 200, nb, nd, ng, nh, tf, ex);
      ctl.drain_ack = 1'b0;
      n_checks++; if (nb != 25) begin n_fail++; $display("FAIL nto_busy: got %0d want 25", nb); end
      n_checks++; if ({ctl.done, ctl.timeout_flag} !== 2'b10) begin n_fail++; $display("FAIL nto_done: got %b want 10", {ctl.done, ctl.timeout_flag}); end
      step();
   endtask
`endif

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      ctl.req_valid = 1'b0;
      ctl.drain_ack = 1'b0;
      test_reset();
      test_late_ack();
      test_early_ack();
      test_back_to_back();
      test_reset_in_hold();
`ifdef L2_RST_SEQ_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/l2_domain_reset_sequencer.md
Name: l2_domain_reset_sequencer

Overview:
- Sits directly upstream of the subsystem_l2 clock-group member.
- Produces the gated clock enable and the domain reset that the clock group forwards to the L2 domain.
- Sequences an L2 domain reset, on power-on or on request: drain handshake, clock gate, reset hold, clock gate, run.
- All outputs are registered, Moore-style, and decoded from the state register.

Parameters:
HOLD_CYCLES, 16, cycles domain_reset is held asserted with clock enabled (>=1)
SETTLE_CYCLES, 4, cycles the clock is gated before and after the hold (>=1)
TIMEOUT_CYCLES, 256, drain-ack wait limit, used only with the optional feature (>=1)
CNT_W, 9, counter width; must hold max(HOLD_CYCLES, SETTLE_CYCLES, TIMEOUT_CYCLES)-1

Ports:
clock  input  1  block clock; the single clock, all logic on its rising edge
reset  input  1  synchronous, active-high block reset
req_valid  input  1  request to reset the L2 domain
req_ready  output  1  high only in RUN; request accepted when req_valid && req_ready
drain_req  output  1  asks L2 to quiesce outstanding traffic
drain_ack  input  1  L2 quiesced
clock_en  output  1  clock-gate enable for the L2 member clock
domain_reset  output  1  reset to the L2 member (feeds the clock group reset input)
busy  output  1  high whenever state != RUN
done  output  1  one-cycle pulse in the first RUN cycle after any sequence
timeout_flag  output  1  sticky drain-timeout indicator (see Optional Feature)

Behaviour:
- States: RUN, DRAIN, GATE_A, HOLD, GATE_B.
- Output decode per state (drain_req / clock_en / domain_reset):
  - RUN: 0 / 1 / 0
  - DRAIN: 1 / 1 / 0
  - GATE_A: 0 / 0 / 0
  - HOLD: 0 / 1 / 1
  - GATE_B: 0 / 0 / 0
- While reset is high:
  - state = HOLD, counter = HOLD_CYCLES-1, done = 0, timeout_flag = 0.
  - Outputs therefore read domain_reset=1, clock_en=1, drain_req=0, req_ready=0, busy=1.
- Timed states (GATE_A, HOLD, GATE_B):
  - The counter loads N-1 on entry and decrements each cycle.
  - The state exits on the cycle after counter==0, so each lasts exactly N cycles.
  - N = SETTLE_CYCLES for GATE_A and GATE_B; N = HOLD_CYCLES for HOLD.
- Transitions:
  - RUN -> DRAIN on an accepted request.
  - DRAIN -> GATE_A the cycle after drain_ack is sampled high. If ack is already high on the first DRAIN cycle, DRAIN lasts 1 cycle.
  - GATE_A -> HOLD -> GATE_B -> RUN per the timed-state rule.
- Outputs change the cycle after the triggering condition; there is no combinational path from any input to any output.
- done:
  - Registered; high for exactly the first cycle of RUN after GATE_B. This includes the power-on sequence.
  - req_ready is also high in that cycle, so a held req_valid is accepted then.
- Requests outside RUN are ignored, not queued.
- drain_ack outside DRAIN is ignored.
- A reset assertion in any state aborts the sequence and restarts at HOLD with a full HOLD_CYCLES count after release.

Optional Feature:
- Macro: L2_RST_SEQ_TIMEOUT_EN.
- Defined:
  - DRAIN loads the counter with TIMEOUT_CYCLES-1.
  - If the counter reaches 0 without ack, the state goes to GATE_A and timeout_flag sets the same cycle GATE_A is entered.
  - A drain_ack on the final count cycle counts as ack, not timeout.
  - timeout_flag clears on reset or on the next accepted request.
- Undefined: DRAIN waits indefinitely for ack; timeout_flag is tied 0.

Test Plan (default parameters):
- Power-on: reset high for 3 cycles, then low -> domain_reset=1/clock_en=1 for 16 cycles, then clock_en=0 for 4, then RUN. done pulses once, req_ready=1, 20 busy cycles after release.
- Request with late ack: req_valid 1 cycle, drain_ack rises in the 5th DRAIN cycle -> drain_req high exactly 5 cycles, then clock_en=0 for 4, domain_reset=1 for 16, clock_en=0 for 4, then done. busy = 29 cycles.
- Ack already high at request -> DRAIN lasts 1 cycle; busy = 25 cycles; drain_req high for 1 cycle.
- req_valid held continuously -> ignored while busy; the next sequence is accepted in the done cycle, and DRAIN starts the following cycle.
- reset pulsed in the 7th HOLD cycle -> domain_reset stays 1 and a full 16-cycle HOLD restarts after release; drain_req never asserts; done follows the power-on timing.
- No ack ever:
  - With L2_RST_SEQ_TIMEOUT_EN: DRAIN lasts 256 cycles, timeout_flag=1 from GATE_A entry, the sequence completes, and the flag clears on the next accepted request.
  - Without it: still in DRAIN after 1000 cycles, timeout_flag=0.
